link_readburst_arb: RTL and testbench

Parametrised multi-channel readburst link. It captures read-burst requests from NCH independent requesters, arbitrates them round-robin, and drives one registered, stable request toward the memory-side readburst responder until that responder signals done. It returns done and data to the granted requester only. It sits between the cache/prefetch readburst clients and the single memory readburst port, replacing per-client single-channel link registers.

---
 rtl/link_readburst_arb_if.sv | 63 ++++++
 rtl/link_readburst_arb.sv | 203 ++++++++++++++++++++
 tb/tb_link_readburst_arb.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/link_readburst_arb_if.sv
// Readburst link bundle: NCH requester channels plus one memory-side
// responder port, shared by the arbiter and its environment.
//
// Modports:
//   slave  - the arbiter: samples requests and responder done/data,
//            drives per-channel done, shared data and the granted request.
//   master - the environment (clients + responder): the mirror image.
interface link_readburst_arb_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 96,
    parameter int DLW = 2,
    parameter int BLW = 4
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]     req_readburst_do;
    logic [NCH-1:0]     req_readburst_done;
    logic [NCH*AW-1:0]  req_readburst_address;
    logic [NCH*DLW-1:0] req_readburst_dword_length;
    logic [NCH*BLW-1:0] req_readburst_byte_length;
    logic [DW-1:0]      req_readburst_data;

    logic               resp_readburst_do;
    logic               resp_readburst_done;
    logic [AW-1:0]      resp_readburst_address;
    logic [DLW-1:0]     resp_readburst_dword_length;
    logic [BLW-1:0]     resp_readburst_byte_length;
    logic [DW-1:0]      resp_readburst_data;
    logic [CW-1:0]      resp_readburst_channel;

    modport slave (
        input  req_readburst_do,
        input  req_readburst_address,
        input  req_readburst_dword_length,
        input  req_readburst_byte_length,
        output req_readburst_done,
        output req_readburst_data,
        output resp_readburst_do,
        output resp_readburst_address,
        output resp_readburst_dword_length,
        output resp_readburst_byte_length,
        output resp_readburst_channel,
        input  resp_readburst_done,
        input  resp_readburst_data
    );

    modport master (
        output req_readburst_do,
        output req_readburst_address,
        output req_readburst_dword_length,
        output req_readburst_byte_length,
        input  req_readburst_done,
        input  req_readburst_data,
        input  resp_readburst_do,
        input  resp_readburst_address,
        input  resp_readburst_dword_length,
        input  resp_readburst_byte_length,
        input  resp_readburst_channel,
        output resp_readburst_done,
        output resp_readburst_data
    );
endinterface

// File: rtl/link_readburst_arb.sv
// Multi-channel readburst link: captures requests from NCH clients,
// grants them round-robin and holds one registered request toward the
// memory readburst responder until it reports done.
//
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - link_readburst_arb_if.slave: per-channel req_* strobes and
//           fields in, per-channel done and shared data out; resp_*
//           request out, responder done/data in.
// REG_RESP=0 returns done/data in the responder's done cycle,
// REG_RESP=1 returns them one cycle later from registers.
module link_readburst_arb #(
    parameter int NCH      = 2,
    parameter int AW       = 32,
    parameter int DW       = 96,
    parameter int DLW      = 2,
    parameter int BLW      = 4,
    parameter int REG_RESP = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    link_readburst_arb_if.slave  bus
);
    localparam int CW = $clog2(NCH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [NCH-1:0]          pending_q, pending_d;
    logic [NCH-1:0][AW-1:0]  addr_q, addr_d;
    logic [NCH-1:0][DLW-1:0] dlen_q, dlen_d;
    logic [NCH-1:0][BLW-1:0] blen_q, blen_d;
    logic [CW-1:0]           last_grant_q, last_grant_d;
    logic [CW-1:0]           chan_q, chan_d;
    logic [AW-1:0]           resp_addr_q, resp_addr_d;
    logic [DLW-1:0]          resp_dlen_q, resp_dlen_d;
    logic [BLW-1:0]          resp_blen_q, resp_blen_d;

    logic [NCH-1:0]          req_done;
    logic [NCH-1:0]          accept;
    logic [NCH-1:0]          cand;
    logic                    found;
    logic [CW-1:0]           gnt;
    logic [CW-1:0]           idx;

    // Done goes only to the granted channel. It depends on state and the
    // responder's done, never on the requests, so no comb loop via accept.
    always_comb begin
        req_done = '0;
        if (REG_RESP == 0) begin
            if (state_q == BUSY && bus.resp_readburst_done) begin
                req_done[chan_q] = 1'b1;
            end
        end else begin
            if (state_q == DONE) begin
                req_done[chan_q] = 1'b1;
            end
        end
    end

    // A channel's do in its own done cycle is ignored, so a request
    // held high through completion is not captured a second time.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NCH; i++) begin
            accept[i] = bus.req_readburst_do[i] && !pending_q[i]
                        && !req_done[i];
        end
        cand = pending_q | accept;
    end

    // Round-robin: first candidate after the last grant, with wrap.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = CW'((int'(last_grant_q) + k) % NCH);
            if (!found && cand[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        addr_d       = addr_q;
        dlen_d       = dlen_q;
        blen_d       = blen_q;
        last_grant_d = last_grant_q;
        chan_d       = chan_q;
        resp_addr_d  = resp_addr_q;
        resp_dlen_d  = resp_dlen_q;
        resp_blen_d  = resp_blen_q;

        for (int i = 0; i < NCH; i++) begin
            if (accept[i]) begin
                pending_d[i] = 1'b1;
                addr_d[i]    = bus.req_readburst_address[i*AW +: AW];
                dlen_d[i]    = bus.req_readburst_dword_length[i*DLW +: DLW];
                blen_d[i]    = bus.req_readburst_byte_length[i*BLW +: BLW];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    // addr_d already holds the live input for a channel
                    // accepted this very cycle.
                    state_d      = BUSY;
                    last_grant_d = gnt;
                    chan_d       = gnt;
                    resp_addr_d  = addr_d[gnt];
                    resp_dlen_d  = dlen_d[gnt];
                    resp_blen_d  = blen_d[gnt];
                end
            end
            BUSY: begin
                if (bus.resp_readburst_done) begin
                    if (REG_RESP == 0) begin
                        pending_d[chan_q] = 1'b0;
                        state_d           = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                pending_d[chan_q] = 1'b0;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            addr_q       <= '0;
            dlen_q       <= '0;
            blen_q       <= '0;
            last_grant_q <= CW'(NCH - 1);
            chan_q       <= '0;
            resp_addr_q  <= '0;
            resp_dlen_q  <= '0;
            resp_blen_q  <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            addr_q       <= addr_d;
            dlen_q       <= dlen_d;
            blen_q       <= blen_d;
            last_grant_q <= last_grant_d;
            chan_q       <= chan_d;
            resp_addr_q  <= resp_addr_d;
            resp_dlen_q  <= resp_dlen_d;
            resp_blen_q  <= resp_blen_d;
        end
    end

    generate
        if (REG_RESP != 0) begin : g_reg_resp
            logic [DW-1:0] data_q, data_d;

            always_comb begin
                data_d = data_q;
                if (state_q == BUSY && bus.resp_readburst_done) begin
                    data_d = bus.resp_readburst_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign bus.req_readburst_data = data_q;
        end else begin : g_comb_resp
            assign bus.req_readburst_data = bus.resp_readburst_data;
        end
    endgenerate

    // Request is derived from state, so an async reset drops it at once.
    assign bus.resp_readburst_do           = (state_q == BUSY);
    assign bus.resp_readburst_address      = resp_addr_q;
    assign bus.resp_readburst_dword_length = resp_dlen_q;
    assign bus.resp_readburst_byte_length  = resp_blen_q;
    assign bus.resp_readburst_channel      = chan_q;
    assign bus.req_readburst_done          = req_done;
endmodule

// File: tb/tb_link_readburst_arb.sv
// Bench for link_readburst_arb: one combinational-response and one
// registered-response instance, checked every cycle against a model.
module tb_link_readburst_arb;
    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 96;
    localparam int DLW = 2;
    localparam int BLW = 4;
    localparam int CW  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    link_readburst_arb_if #(.NCH(NCH), .AW(AW), .DW(DW), .DLW(DLW),
        .BLW(BLW)) bus0 ();
    link_readburst_arb_if #(.NCH(NCH), .AW(AW), .DW(DW), .DLW(DLW),
        .BLW(BLW)) bus1 ();

    link_readburst_arb #(.NCH(NCH), .AW(AW), .DW(DW), .DLW(DLW),
        .BLW(BLW), .REG_RESP(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    link_readburst_arb #(.NCH(NCH), .AW(AW), .DW(DW), .DLW(DLW),
        .BLW(BLW), .REG_RESP(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_chk = 0;
    int n_bad = 0;

    // shared request stimulus
    logic [NCH-1:0] s_do;
    logic [AW-1:0]  s_addr [NCH];
    logic [DLW-1:0] s_dl [NCH];
    logic [BLW-1:0] s_bl [NCH];
    bit             spur_en;
    bit             fix_en;
    logic [DW-1:0]  fix_data;

    // per-instance responder drive
    logic           r_done [2];
    logic [DW-1:0]  r_data [2];

    // model: d=0 answers in the done cycle, d=1 one cycle later
    bit             m_pend  [2][NCH];
    logic [AW-1:0]  m_addr  [2][NCH];
    logic [DLW-1:0] m_dl    [2][NCH];
    logic [BLW-1:0] m_bl    [2][NCH];
    int             m_phase [2];  // 0 free, 1 in flight, 2 reporting
    int             m_owner [2];
    int             m_last  [2];
    int             m_wait  [2];
    logic [AW-1:0]  m_ra    [2];
    logic [DLW-1:0] m_rdl   [2];
    logic [BLW-1:0] m_rbl   [2];
    logic [DW-1:0]  m_saved [2];

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NCH; i++) begin
                m_pend[d][i] = 1'b0;
                m_addr[d][i] = '0;
                m_dl[d][i]   = '0;
                m_bl[d][i]   = '0;
            end
            m_phase[d] = 0;
            m_owner[d] = 0;
            m_last[d]  = NCH - 1;
            m_wait[d]  = 0;
            m_ra[d]    = '0;
            m_rdl[d]   = '0;
            m_rbl[d]   = '0;
            m_saved[d] = '0;
            r_done[d]  = 1'b0;
            r_data[d]  = '0;
        end
    endtask

    task automatic drive_quiet();
        bus0.req_readburst_do = '0;
        bus1.req_readburst_do = '0;
        bus0.req_readburst_address = '0;
        bus1.req_readburst_address = '0;
        bus0.req_readburst_dword_length = '0;
        bus1.req_readburst_dword_length = '0;
        bus0.req_readburst_byte_length = '0;
        bus1.req_readburst_byte_length = '0;
        bus0.resp_readburst_done = 1'b0;
        bus1.resp_readburst_done = 1'b0;
        bus0.resp_readburst_data = '0;
        bus1.resp_readburst_data = '0;
    endtask

    task automatic sample(input int d, output logic a_do,
                          output logic [AW-1:0] a_addr,
                          output logic [DLW-1:0] a_dl,
                          output logic [BLW-1:0] a_bl,
                          output logic [CW-1:0] a_ch,
                          output logic [NCH-1:0] a_done,
                          output logic [DW-1:0] a_data);
        if (d == 0) begin
            a_do   = bus0.resp_readburst_do;
            a_addr = bus0.resp_readburst_address;
            a_dl   = bus0.resp_readburst_dword_length;
            a_bl   = bus0.resp_readburst_byte_length;
            a_ch   = bus0.resp_readburst_channel;
            a_done = bus0.req_readburst_done;
            a_data = bus0.req_readburst_data;
        end else begin
            a_do   = bus1.resp_readburst_do;
            a_addr = bus1.resp_readburst_address;
            a_dl   = bus1.resp_readburst_dword_length;
            a_bl   = bus1.resp_readburst_byte_length;
            a_ch   = bus1.resp_readburst_channel;
            a_done = bus1.req_readburst_done;
            a_data = bus1.req_readburst_data;
        end
    endtask

    task automatic check_all(input int d, output logic [NCH-1:0] ed);
        logic           a_do;
        logic [AW-1:0]  a_addr;
        logic [DLW-1:0] a_dl;
        logic [BLW-1:0] a_bl;
        logic [CW-1:0]  a_ch;
        logic [NCH-1:0] a_done;
        logic [DW-1:0]  a_data;
        logic [DW-1:0]  ex_data;
        ed = '0;
        ex_data = '0;
        if (d == 0 && m_phase[0] == 1 && r_done[0]) begin
            ed[m_owner[0]] = 1'b1;
            ex_data = r_data[0];
        end
        if (d == 1 && m_phase[1] == 2) begin
            ed[m_owner[1]] = 1'b1;
            ex_data = m_saved[1];
        end
        sample(d, a_do, a_addr, a_dl, a_bl, a_ch, a_done, a_data);
        check($sformatf("d%0d resp_do", d), a_do, m_phase[d] == 1);
        check($sformatf("d%0d channel", d), a_ch, m_owner[d]);
        check($sformatf("d%0d address", d), a_addr, m_ra[d]);
        check($sformatf("d%0d dword_len", d), a_dl, m_rdl[d]);
        check($sformatf("d%0d byte_len", d), a_bl, m_rbl[d]);
        check($sformatf("d%0d req_done", d), a_done, ed);
        if (ed != '0) begin
            check($sformatf("d%0d req_data", d), a_data, ex_data);
        end
    endtask

    task automatic step(input int d, input logic [NCH-1:0] ed);
        int  c;
        bit  hit;
        for (int i = 0; i < NCH; i++) begin
            if (s_do[i] && !m_pend[d][i] && !ed[i]) begin
                m_pend[d][i] = 1'b1;
                m_addr[d][i] = s_addr[i];
                m_dl[d][i]   = s_dl[i];
                m_bl[d][i]   = s_bl[i];
            end
        end
        case (m_phase[d])
            0: begin
                hit = 1'b0;
                for (int k = 1; k <= NCH; k++) begin
                    c = (m_last[d] + k) % NCH;
                    if (!hit && m_pend[d][c]) begin
                        hit = 1'b1;
                        m_owner[d] = c;
                    end
                end
                if (hit) begin
                    m_phase[d] = 1;
                    m_last[d]  = m_owner[d];
                    m_ra[d]    = m_addr[d][m_owner[d]];
                    m_rdl[d]   = m_dl[d][m_owner[d]];
                    m_rbl[d]   = m_bl[d][m_owner[d]];
                    m_wait[d]  = $urandom_range(0, 3);
                end
            end
            1: begin
                if (r_done[d]) begin
                    if (d == 0) begin
                        m_pend[d][m_owner[d]] = 1'b0;
                        m_phase[d] = 0;
                    end else begin
                        m_saved[d] = r_data[d];
                        m_phase[d] = 2;
                    end
                end else begin
                    m_wait[d]--;
                end
            end
            default: begin
                m_pend[d][m_owner[d]] = 1'b0;
                m_phase[d] = 0;
            end
        endcase
    endtask

    task automatic tick();
        logic [NCH-1:0] ed;
        @(negedge clk);
        bus0.req_readburst_do = s_do;
        bus1.req_readburst_do = s_do;
        for (int i = 0; i < NCH; i++) begin
            bus0.req_readburst_address[i*AW +: AW] = s_addr[i];
            bus1.req_readburst_address[i*AW +: AW] = s_addr[i];
            bus0.req_readburst_dword_length[i*DLW +: DLW] = s_dl[i];
            bus1.req_readburst_dword_length[i*DLW +: DLW] = s_dl[i];
            bus0.req_readburst_byte_length[i*BLW +: BLW] = s_bl[i];
            bus1.req_readburst_byte_length[i*BLW +: BLW] = s_bl[i];
        end
        for (int d = 0; d < 2; d++) begin
            if (m_phase[d] == 1) begin
                r_done[d] = (m_wait[d] <= 0);
            end else begin
                r_done[d] = spur_en && ($urandom_range(0, 5) == 0);
            end
            r_data[d] = fix_en ? fix_data : {$urandom(), $urandom(), $urandom()};
        end
        bus0.resp_readburst_done = r_done[0];
        bus0.resp_readburst_data = r_data[0];
        bus1.resp_readburst_done = r_done[1];
        bus1.resp_readburst_data = r_data[1];
        #1;
        for (int d = 0; d < 2; d++) begin
            check_all(d, ed);
            step(d, ed);
        end
    endtask

    task automatic idle_ticks(input int n);
        s_do = '0;
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        logic [NCH-1:0] ed;
        rst_n = 1'b0;
        drive_quiet();
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            check_all(d, ed);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        s_do     = '0;
        spur_en  = 1'b0;
        fix_en   = 1'b0;
        fix_data = '0;
        for (int i = 0; i < NCH; i++) begin
            s_addr[i] = '0;
            s_dl[i]   = '0;
            s_bl[i]   = '0;
        end
        drive_quiet();
        model_reset();
        #1;
        apply_reset();

        // single burst on ch0, fixed data pattern
        fix_en   = 1'b1;
        fix_data = {12{8'hA5}};
        s_addr[0] = 32'h0000_1000;
        s_dl[0]   = 2'd2;
        s_bl[0]   = 4'd12;
        s_do      = 2'b01;
        tick();
        idle_ticks(10);
        fix_en = 1'b0;

        // contention, then both again
        for (int r = 0; r < 2; r++) begin
            s_addr[0] = 32'h0000_2000 + r;
            s_addr[1] = 32'h0000_3000 + r;
            s_dl[0]   = 2'd1;
            s_dl[1]   = 2'd3;
            s_bl[0]   = 4'd5;
            s_bl[1]   = 4'd9;
            s_do      = 2'b11;
            tick();
            idle_ticks(14);
        end

        // held do on ch1 through completion, then a fresh request
        s_addr[1] = 32'hCAFE_0000;
        s_do      = 2'b10;
        repeat (10) tick();
        idle_ticks(2);
        s_do = 2'b10;
        tick();
        idle_ticks(10);

        // ch0 fields change while pending
        s_addr[0] = 32'h1111_1111;
        s_do      = 2'b01;
        tick();
        for (int j = 0; j < 6; j++) begin
            s_addr[0] = $urandom();
            s_dl[0]   = DLW'($urandom());
            s_bl[0]   = BLW'($urandom());
            tick();
        end
        idle_ticks(8);

        // reset while both instances hold a burst
        s_addr[0] = 32'h0BAD_0000;
        s_do      = 2'b01;
        tick();
        @(negedge clk);
        #2;
        apply_reset();
        idle_ticks(2);
        s_do = 2'b11;
        tick();
        idle_ticks(14);

        // random traffic with stray responder done pulses
        spur_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NCH; i++) begin
                s_do[i]   = ($urandom_range(0, 3) == 0);
                s_addr[i] = $urandom();
                s_dl[i]   = DLW'($urandom());
                s_bl[i]   = BLW'($urandom());
            end
            tick();
        end
        spur_en = 1'b0;
        idle_ticks(14);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
